// File: rtl/nn_pkg.sv
// Shared constants and types for the RNN output classifier blocks.
package nn_pkg;

    localparam int          DATA_W  = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    localparam int BEATS = 9;
    localparam int STEPS = 3;
    localparam int ELEMS = 3;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/nn_fp_cmp.sv
// Combinational single-precision a > b with denormals flushed to zero.
module nn_fp_cmp
    import nn_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              gt_o
);

    logic a_zero, b_zero, a_neg, b_neg;
    logic [DATA_W-2:0] a_mag, b_mag;

    assign a_zero = (a_i[DATA_W-2 -: 8] == 8'd0);
    assign b_zero = (b_i[DATA_W-2 -: 8] == 8'd0);
    assign a_neg  = a_i[DATA_W-1];
    assign b_neg  = b_i[DATA_W-1];
    assign a_mag  = a_i[DATA_W-2:0];
    assign b_mag  = b_i[DATA_W-2:0];

    always_comb begin
        gt_o = 1'b0;
        if (a_zero && b_zero) begin
            gt_o = 1'b0;
        end else if (a_zero) begin
            gt_o = b_neg;
        end else if (b_zero) begin
            gt_o = !a_neg;
        end else if (a_neg != b_neg) begin
            gt_o = !a_neg;
        end else if (!a_neg) begin
            gt_o = (a_mag > b_mag);
        end else begin
            // Larger magnitude is the smaller value for negatives.
            gt_o = (a_mag < b_mag);
        end
    end

endmodule

// File: rtl/nn_y_argmax.sv
// Per-timestep argmax over the RNN core's 9-beat output burst, with a
// small result buffer drained through a valid/ready handshake.
module nn_y_argmax #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [1:0]        out_step,
    output logic [1:0]        out_cls,
    output logic [DATA_W-1:0] out_max,
    output logic              ovf,
    output logic              err
);
    import nn_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [1:0]        step;
        logic [1:0]        cls;
        logic [DATA_W-1:0] max;
    } result_t;

    state_t            state_q, state_d;
    logic [1:0]        elem_q, elem_d, step_q, step_d;
    logic              wait_low_q, wait_low_d;
    logic              err_q, err_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [1:0]        idx_q, idx_d;
    result_t           mem_q [FIFO_DEPTH];
    result_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d, wr_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    result_t           out_q, out_d;
    logic              beat_en, gt, push, pop, push_ok;
    result_t           res;

    nn_fp_cmp u_cmp (
        .a_i  (in_data),
        .b_i  (max_q),
        .gt_o (gt)
    );

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        step_d     = step_q;
        wait_low_d = wait_low_q && in_valid;
        err_d      = err_q;
        max_d      = max_q;
        idx_d      = idx_q;
        beat_en    = 1'b0;
        case (state_q)
            IDLE: begin
                // After a reset mid-burst, wait for in_valid to drop first.
                if (in_valid && !wait_low_q) begin
                    beat_en = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    beat_en = 1'b1;
                end else begin
                    state_d = IDLE;
                    if (elem_q != 2'd0 || step_q != 2'd0) err_d = 1'b1;
                    elem_d  = 2'd0;
                    step_d  = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (beat_en) begin
            if (elem_q == 2'(ELEMS - 1)) begin
                elem_d = 2'd0;
                step_d = (step_q == 2'(STEPS - 1)) ? 2'd0 : step_q + 2'd1;
            end else begin
                elem_d = elem_q + 2'd1;
            end
            if (elem_q == 2'd0) begin
                max_d = in_data;
                idx_d = 2'd0;
            end else if (gt) begin
                max_d = in_data;
                idx_d = elem_q;
            end
        end
    end

    assign push     = beat_en && (elem_q == 2'(ELEMS - 1));
    assign res.step = step_q;
    assign res.cls  = gt ? elem_q : idx_q;
    assign res.max  = gt ? in_data : max_q;
    assign pop      = out_ready && (cnt_q != '0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push && ((cnt_q != CNT_W'(FIFO_DEPTH)) || pop);
    assign wr_idx   = rd_q + cnt_q[PTR_W-1:0];

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        if (push_ok) mem_d[wr_idx] = res;
        rd_d        = pop ? rd_q + PTR_W'(1) : rd_q;
        cnt_d       = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        ovf_d       = ovf_q || (push && !push_ok);
        out_valid_d = (cnt_d != '0);
        out_d       = out_valid_d ? mem_d[rd_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            elem_q      <= 2'd0;
            step_q      <= 2'd0;
            wait_low_q  <= in_valid;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            rd_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            step_q      <= step_d;
            wait_low_q  <= wait_low_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        max_q <= max_d;
        idx_q <= idx_d;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    assign out_valid = out_valid_q;
    assign out_step  = out_q.step;
    assign out_cls   = out_q.cls;
    assign out_max   = out_q.max;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_nn_y_argmax.sv
// Directed bench for nn_y_argmax with a real-valued argmax reference model.
module tb_nn_y_argmax;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [1:0]  out_step;
    logic [1:0]  out_cls;
    logic [31:0] out_max;
    logic        ovf;
    logic        err;

    nn_y_argmax #(.FIFO_DEPTH(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_step  (out_step),
        .out_cls   (out_cls),
        .out_max   (out_max),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected buffer contents and sticky flags; entries are {step, cls, max}.
    logic [35:0] mq[$];
    logic [35:0] plog[$];
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;
    bit          exp_push = 1'b0;
    bit          exp_err_set = 1'b0;
    logic [35:0] exp_entry = '0;
    bit          chk_en = 1'b0;
    logic [31:0] bv [0:17];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        int  e;
        real m;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    function automatic logic [35:0] group_result(input int step, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] c);
        logic [31:0] v [3];
        int best;
        v[0] = a; v[1] = b; v[2] = c;
        best = 0;
        for (int k = 1; k < 3; k++)
            if (f2r(v[k]) > f2r(v[best])) best = k;
        return {2'(step), 2'(best), v[best]};
    endfunction

    // Reference buffer: pop happens before push, so a full buffer with a pop accepts.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_err = 1'b0;
        end else begin
            if (out_ready && mq.size() > 0) begin
                void'(mq.pop_front());
                if (out_valid) plog.push_back({out_step, out_cls, out_max});
            end
            if (exp_push) begin
                if (mq.size() < 4) mq.push_back(exp_entry);
                else m_ovf = 1'b1;
            end
            if (exp_err_set) m_err = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("out_step", out_step, mq[0][35:34]);
                chk("out_cls",  out_cls,  mq[0][33:32]);
                chk("out_max",  out_max,  mq[0][31:0]);
            end
            chk("ovf", ovf, m_ovf);
            chk("err", err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_burst(input int n, input int rst_at, input int ready_at);
        bit dead;
        dead = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = bv[i];
            rst      = (i == rst_at);
            if (i == ready_at) out_ready = 1'b1;
            if (i == rst_at) dead = 1'b1;
            exp_push = !dead && (i % 3 == 2);
            if (exp_push) exp_entry = group_result((i % 9) / 3, bv[i-2], bv[i-1], bv[i]);
            tick();
            if (i == rst_at) begin
                chk("rst_valid", out_valid, 0);
                chk("rst_step",  out_step,  0);
                chk("rst_cls",   out_cls,   0);
                chk("rst_max",   out_max,   0);
                chk("rst_ovf",   ovf,       0);
                chk("rst_err",   err,       0);
            end
        end
        in_valid    = 1'b0;
        rst         = 1'b0;
        exp_push    = 1'b0;
        exp_err_set = !dead && (n % 9 != 0);
        tick();
        exp_err_set = 1'b0;
    endtask

    task automatic load_basic();
        bv[0] = 32'h3F000000; bv[1] = 32'h40000000; bv[2] = 32'h3F800000;
        bv[3] = 32'h00000000; bv[4] = 32'h00000000; bv[5] = 32'h00000000;
        bv[6] = 32'h3F800000; bv[7] = 32'h3F800000; bv[8] = 32'h40400000;
    endtask

    task automatic check_basic(input string tag, input int base);
        logic [35:0] want [3];
        want[0] = 36'h1_4000_0000;
        want[1] = 36'h4_0000_0000;
        want[2] = 36'hA_4040_0000;
        chk({tag, "_count"}, plog.size() - base, 3);
        for (int k = 0; k < 3; k++)
            if (base + k < plog.size()) chk({tag, "_res"}, plog[base+k], want[k]);
    endtask

    initial begin
        int base;
        logic [1:0] steps_want [4];
        steps_want[0] = 2'd0; steps_want[1] = 2'd1; steps_want[2] = 2'd2; steps_want[3] = 2'd0;

        tick();
        chk_en = 1'b1;
        idle(2);
        rst = 1'b0;
        tick();
        chk("reset_valid", out_valid, 0);
        chk("reset_step",  out_step,  0);
        chk("reset_cls",   out_cls,   0);
        chk("reset_max",   out_max,   0);
        chk("reset_ovf",   ovf,       0);
        chk("reset_err",   err,       0);

        // Single burst, free-flowing consumer.
        out_ready = 1'b1;
        load_basic();
        base = plog.size();
        send_burst(9, -1, -1);
        idle(3);
        check_basic("single", base);
        chk("single_ovf", ovf, 0);
        chk("single_err", err, 0);

        // Ties, flushed denormal, signed zero, negatives.
        bv[0] = 32'h80000000; bv[1] = 32'h00000001; bv[2] = 32'h00000000;
        bv[3] = 32'h3F800000; bv[4] = 32'hBF800000; bv[5] = 32'h3F800000;
        bv[6] = 32'hBF800000; bv[7] = 32'hC0000000; bv[8] = 32'hBF000000;
        base = plog.size();
        send_burst(9, -1, -1);
        idle(3);
        chk("tie_count", plog.size() - base, 3);
        if (base + 2 < plog.size()) begin
            chk("tie_zero", plog[base],   36'h0_8000_0000);
            chk("tie_pos",  plog[base+1], 36'h4_3F80_0000);
            chk("tie_neg",  plog[base+2], 36'hA_BF00_0000);
        end

        // Backpressure over two back-to-back bursts.
        out_ready = 1'b0;
        load_basic();
        for (int i = 9; i < 18; i++) bv[i] = 32'h3F800000 + 32'(i) * 32'h00100000;
        send_burst(18, -1, -1);
        chk("bp_ovf",   ovf,       1);
        chk("bp_valid", out_valid, 1);
        base = plog.size();
        out_ready = 1'b1;
        idle(6);
        chk("bp_count", plog.size() - base, 4);
        for (int k = 0; k < 4; k++)
            if (base + k < plog.size()) chk("bp_step", plog[base+k][35:34], steps_want[k]);
        do_reset();

        // Short burst, then a clean full burst.
        load_basic();
        base = plog.size();
        send_burst(5, -1, -1);
        chk("short_err", err, 1);
        chk("short_count", plog.size() - base, 1);
        base = plog.size();
        send_burst(9, -1, -1);
        idle(3);
        check_basic("after_short", base);
        do_reset();

        // Full buffer with simultaneous push and pop.
        out_ready = 1'b0;
        base = plog.size();
        send_burst(18, -1, 14);
        idle(6);
        chk("full_ovf", ovf, 0);
        chk("full_count", plog.size() - base, 6);

        // Reset in the middle of a burst.
        out_ready = 1'b0;
        load_basic();
        send_burst(9, 4, -1);
        idle(3);
        chk("post_rst_valid", out_valid, 0);
        out_ready = 1'b1;
        base = plog.size();
        send_burst(9, -1, -1);
        idle(3);
        check_basic("post_rst", base);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
